imager_apb_drain: RTL and testbench
===================================

IMAGER_APB_DRAIN -- requirements
Module: imager_apb_drain

Interface
REQ-001 Parameters SHALL be, one per line:
- STATUS_ADDR, 32'h0000_0004: APB address of the camera FIFO status register.
- DATA_ADDR, 32'h0000_0008: APB address of the camera FIFO read-data register.
- EMPTY_BIT, 0: PRDATA bit index that reads 1 when the FIFO is empty.
- TIMEOUT, 255: maximum number of ACCESS-phase cycles with PREADY=0 before abort.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin draining.
- word_count  in  16  number of words to drain; sampled when start is accepted.
- busy  out  1  high from start acceptance until return to IDLE.
- done  out  1  one-cycle pulse when word_count words have been delivered.
- error  out  1  one-cycle pulse when a transfer aborts.
- m_data  out  32  output stream data.
- m_valid  out  1  output stream valid.
- m_ready  in  1  output stream ready.
- PSEL, PENABLE, PWRITE  out  1 each  APB3 initiator controls.
- PADDR, PWDATA  out  32 each  APB address and write data.
- PREADY, PSLVERR  in  1 each  APB responder handshake and error.
- PRDATA  in  32  APB read data.

Function
REQ-003 The state machine SHALL have the states IDLE, STAT_SETUP, STAT_ACCESS, DATA_SETUP, DATA_ACCESS, PUSH and DONE.
REQ-004 In IDLE, a start with word_count>0 SHALL latch the remaining count and go to STAT_SETUP.
REQ-005 In IDLE, a start with word_count=0 SHALL go to DONE without any APB traffic.
REQ-006 A start while busy=1 SHALL be ignored.
REQ-007 The module SHALL only issue reads: PWRITE=0 and PWDATA=0 at all times.
REQ-008 In the SETUP states, PSEL=1, PENABLE=0 and PADDR=STATUS_ADDR or DATA_ADDR, for exactly one cycle.
REQ-009 In the ACCESS states, PSEL=1, PENABLE=1 and the same PADDR SHALL be held until PREADY=1; the transfer completes on that cycle.
REQ-010 In every other state, PSEL=0, PENABLE=0 and PADDR=0.
REQ-011 On STAT_ACCESS completion, PRDATA[EMPTY_BIT]=1 SHALL go to STAT_SETUP (repoll) and 0 SHALL go to DATA_SETUP.
REQ-012 On DATA_ACCESS completion, PRDATA SHALL be registered into m_data and the state SHALL go to PUSH.
REQ-013 In PUSH, m_valid=1 and m_data SHALL be held stable until m_ready=1.
REQ-014 On the PUSH handshake, the count SHALL decrement; the next state is DONE when the count reaches 0, otherwise STAT_SETUP.
REQ-015 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-016 PSLVERR=1 on any completing transfer SHALL abort: error=1 for one cycle, next state IDLE, data discarded, no done pulse.
REQ-017 A timeout counter SHALL clear on entering each ACCESS state and increment on each PREADY=0 cycle.
REQ-018 When the timeout counter reaches TIMEOUT, the transfer SHALL abort as in REQ-016, with PSEL dropped on the following cycle.
REQ-019 With PREADY=1 and m_ready=1 throughout, latency SHALL be exactly 5 cycles per word; start to first m_valid is 5 cycles.
REQ-020 busy SHALL equal (state != IDLE) and be registered.
REQ-021 The count SHALL be 16-bit unsigned with no wrap: decrementing at 1 ends the transfer, and 0 is never decremented.

Reset
REQ-022 Asserting reset (reset=0) SHALL asynchronously force state IDLE, count 0, timeout counter 0, and all outputs 0, including m_data, PADDR and PWDATA.
REQ-023 A reset asserted mid-transfer SHALL drop PSEL and m_valid immediately, with no done or error pulse.
REQ-024 Deassertion of reset SHALL be synchronous to clk; the module SHALL then accept start on the first rising edge after deassertion.

Structure
REQ-025 The state enumeration and the default STATUS_ADDR and DATA_ADDR constants SHALL reside in the shared package imager_pkg.
REQ-026 The PREADY timeout counter SHALL be a sub-module named apb_timeout, with inputs clear, tick and limit and output expired.

Verification
REQ-027 Scenario 1: start, word_count=3, PREADY=1, status empty bit=0, PRDATA data 32'hA1,32'hA2,32'hA3, m_ready=1 -> three m_valid beats carrying A1,A2,A3 at 5-cycle spacing, done on cycle 16, busy low on cycle 17.
REQ-028 Scenario 2: status returns empty bit=1 twice, then 0 -> two extra status reads at STATUS_ADDR, one DATA_ADDR read, one beat delivered.
REQ-029 Scenario 3: m_ready held 0 for 10 cycles during PUSH -> m_data stable, PSEL=0 for all 10 cycles.
REQ-030 Scenario 4: PSLVERR=1 on the second data read of word_count=4 -> one beat delivered, one-cycle error pulse, no done, IDLE.
REQ-031 Scenario 5: PREADY held 0 with TIMEOUT=8 -> error pulse after 8 wait cycles, PSEL low next cycle.
REQ-032 Scenario 6: reset asserted during DATA_ACCESS, then start with word_count=0 after release -> all outputs 0 immediately, then done 1 cycle after start with no APB activity.

Source files
------------

// File: rtl/imager_pkg.sv
// Shared state encoding and default register map for the imager APB drain engine.
package imager_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_STAT_SETUP  = 3'd1,
    ST_STAT_ACCESS = 3'd2,
    ST_DATA_SETUP  = 3'd3,
    ST_DATA_ACCESS = 3'd4,
    ST_PUSH        = 3'd5,
    ST_DONE        = 3'd6
  } drain_state_t;

  localparam logic [31:0] DEF_STATUS_ADDR = 32'h0000_0004;
  localparam logic [31:0] DEF_DATA_ADDR   = 32'h0000_0008;
  localparam int          TO_W            = 16;

  function automatic logic is_setup(input drain_state_t s);
    return (s == ST_STAT_SETUP) || (s == ST_DATA_SETUP);
  endfunction

  function automatic logic is_access(input drain_state_t s);
    return (s == ST_STAT_ACCESS) || (s == ST_DATA_ACCESS);
  endfunction

endpackage

// File: rtl/apb_timeout.sv
// Counts PREADY=0 cycles of one APB access; expired flags the wait cycle
// that brings the count up to the limit, so the caller can abort on that edge.
module apb_timeout
  import imager_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            tick,
  input  logic [TO_W-1:0] limit,
  output logic            expired
);

  logic [TO_W-1:0] r_cnt;

  // wait-cycle counter, restarted before every access phase
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= r_cnt + TO_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign expired = tick && (r_cnt == (limit - TO_W'(1)));

endmodule

// File: rtl/imager_apb_drain.sv
// Drains a camera FIFO over APB: polls the status register until not empty,
// reads one data word, pushes it on a valid/ready stream, repeats word_count times.
module imager_apb_drain
  import imager_pkg::*;
#(
  parameter logic [31:0] STATUS_ADDR = DEF_STATUS_ADDR,
  parameter logic [31:0] DATA_ADDR   = DEF_DATA_ADDR,
  parameter int          EMPTY_BIT   = 0,
  parameter int          TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] word_count,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic        PREADY,
  input  logic        PSLVERR,
  input  logic [31:0] PRDATA
);

  localparam logic [TO_W-1:0] LP_LIMIT     = TO_W'(TIMEOUT);
  localparam logic [4:0]      LP_EMPTY_IDX = 5'(EMPTY_BIT);

  drain_state_t r_state, w_state_nx;
  logic [15:0]  r_count, w_count_nx;
  logic [31:0]  w_paddr_nx;
  logic         w_abort, w_capture, w_expired, w_tick;
  logic         r_busy, r_done, r_error, r_m_valid, r_psel, r_penable;
  logic [31:0]  r_m_data, r_paddr;

  assign w_tick = is_access(r_state) && !PREADY;

  apb_timeout u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (is_setup(r_state)),
    .tick    (w_tick),
    .limit   (LP_LIMIT),
    .expired (w_expired)
  );

  // next-state, count and capture decisions
  always_comb begin
    w_state_nx = r_state;
    w_count_nx = r_count;
    w_abort    = 1'b0;
    w_capture  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && (word_count != 16'd0)) begin
          w_state_nx = ST_STAT_SETUP;
          w_count_nx = word_count;
        end else if (start) begin
          w_state_nx = ST_DONE;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_STAT_SETUP:  w_state_nx = ST_STAT_ACCESS;
      ST_STAT_ACCESS: begin
        if (w_expired || (PREADY && PSLVERR)) begin
          w_abort    = 1'b1;
          w_count_nx = 16'd0;
          w_state_nx = ST_IDLE;
        end else if (PREADY) begin
          w_state_nx = PRDATA[LP_EMPTY_IDX] ? ST_STAT_SETUP : ST_DATA_SETUP;
        end else begin
          w_state_nx = ST_STAT_ACCESS;
        end
      end
      ST_DATA_SETUP:  w_state_nx = ST_DATA_ACCESS;
      ST_DATA_ACCESS: begin
        if (w_expired || (PREADY && PSLVERR)) begin
          w_abort    = 1'b1;
          w_count_nx = 16'd0;
          w_state_nx = ST_IDLE;
        end else if (PREADY) begin
          w_capture  = 1'b1;
          w_state_nx = ST_PUSH;
        end else begin
          w_state_nx = ST_DATA_ACCESS;
        end
      end
      ST_PUSH: begin
        // the count saturates at zero; the last word ends the transfer
        if (m_ready && (r_count > 16'd1)) begin
          w_count_nx = r_count - 16'd1;
          w_state_nx = ST_STAT_SETUP;
        end else if (m_ready) begin
          w_count_nx = 16'd0;
          w_state_nx = ST_DONE;
        end else begin
          w_state_nx = ST_PUSH;
        end
      end
      ST_DONE: w_state_nx = ST_IDLE;
      default: begin
        w_count_nx = 16'd0;
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // APB address decode for the upcoming state
  always_comb begin
    if ((w_state_nx == ST_STAT_SETUP) || (w_state_nx == ST_STAT_ACCESS)) begin
      w_paddr_nx = STATUS_ADDR;
    end else if ((w_state_nx == ST_DATA_SETUP) || (w_state_nx == ST_DATA_ACCESS)) begin
      w_paddr_nx = DATA_ADDR;
    end else begin
      w_paddr_nx = 32'h0000_0000;
    end
  end

  // state, count and all outputs registered from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_count   <= 16'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_data  <= 32'h0000_0000;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_paddr   <= 32'h0000_0000;
    end else begin
      r_state   <= w_state_nx;
      r_count   <= w_count_nx;
      r_busy    <= (w_state_nx != ST_IDLE);
      r_done    <= (w_state_nx == ST_DONE);
      r_error   <= w_abort;
      r_m_valid <= (w_state_nx == ST_PUSH);
      r_psel    <= is_setup(w_state_nx) || is_access(w_state_nx);
      r_penable <= is_access(w_state_nx);
      r_paddr   <= w_paddr_nx;
      if (w_capture) begin
        r_m_data <= PRDATA;
      end else begin
        r_m_data <= r_m_data;
      end
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign error   = r_error;
  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign PSEL    = r_psel;
  assign PENABLE = r_penable;
  assign PADDR   = r_paddr;
  assign PWRITE  = 1'b0;
  assign PWDATA  = 32'h0000_0000;

endmodule

// File: tb/tb_imager_apb_drain.sv
// Randomized bench: an APB responder and stream sink model the FIFO side and
// predict the delivered words, counts, pulses and cycle timing.
module tb_imager_apb_drain;
  import imager_pkg::*;

  localparam logic [31:0] SA = DEF_STATUS_ADDR;
  localparam logic [31:0] DA = DEF_DATA_ADDR;
  localparam int          TO = 8;

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, m_ready = 1'b0;
  logic [15:0] word_count = 16'd0;
  logic        busy, done, error, m_valid, PSEL, PENABLE, PWRITE;
  logic [31:0] m_data, PADDR, PWDATA;
  logic        PREADY = 1'b0, PSLVERR = 1'b0;
  logic [31:0] PRDATA = 32'h0;

  imager_apb_drain #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .busy(busy), .done(done), .error(error),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  always #5 clk = ~clk;

  int n_total = 0, n_bad = 0, cyc = 0;
  int max_wait = 0, empty_pct = 0, mready_pct = 100, err_at = 0, forced_empty = 0, mready_block = 0;
  bit hang = 1'b0;
  logic [31:0] data_src[$];
  logic [31:0] exp_q[$];
  int beat_cyc[$];
  int n_stat_rd, n_data_rd, n_empty, n_beats, n_done, n_err, n_stall, n_psel;
  int done_cyc, err_wait, wait_run, waits_left;
  bit err_prev_acc, emp;
  logic prev_psel, prev_pen, prev_pready, prev_mvalid, prev_mready, prev_err;
  logic [31:0] prev_paddr, prev_mdata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    n_stat_rd = 0; n_data_rd = 0; n_empty = 0; n_beats = 0; n_done = 0; n_err = 0;
    n_stall = 0; n_psel = 0; done_cyc = -1; err_wait = -1; err_prev_acc = 1'b0;
    beat_cyc.delete(); exp_q.delete();
  endtask

  // APB responder, stream sink and protocol monitor, evaluated mid-cycle
  initial begin : bus_model
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        PREADY = 1'b0; PSLVERR = 1'b0; m_ready = 1'b0;
        prev_psel = 1'b0; prev_pen = 1'b0; prev_pready = 1'b0;
        prev_mvalid = 1'b0; prev_mready = 1'b0; prev_err = 1'b0; wait_run = 0;
      end else begin
        check_eq("read_only", PWDATA | {31'd0, PWRITE}, 32'd0);
        if (PSEL) n_psel++;
        if (!PSEL) begin
          check_eq("idle_bus", PADDR | {31'd0, PENABLE}, 32'd0);
        end else if (!PENABLE) begin
          check_eq("setup_addr", 32'((PADDR == SA) || (PADDR == DA)), 32'd1);
          waits_left = int'($urandom_range(max_wait, 0));
          wait_run = 0;
        end else begin
          check_eq("acc_addr", PADDR, prev_paddr);
          check_eq("acc_seq", 32'(prev_psel && (!prev_pen || !prev_pready)), 32'd1);
        end
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = $urandom;
        if (PSEL && PENABLE) begin
          if (hang || waits_left > 0) begin
            waits_left--; wait_run++;
            PSLVERR = 1'($urandom_range(1, 0));
          end else begin
            PREADY = 1'b1;
            if (PADDR == SA) begin
              n_stat_rd++;
              if (forced_empty > 0) begin
                forced_empty--; emp = 1'b1;
              end else begin
                emp = ($urandom_range(99, 0) < 32'(empty_pct));
              end
              PRDATA[0] = emp;
              if (emp) n_empty++;
            end else begin
              n_data_rd++;
              if (data_src.size() > 0) PRDATA = data_src.pop_front();
              if (n_data_rd == err_at) PSLVERR = 1'b1;
              else exp_q.push_back(PRDATA);
            end
          end
        end
        if (mready_block > 0 && m_valid) begin
          m_ready = 1'b0; mready_block--;
        end else begin
          m_ready = ($urandom_range(99, 0) < 32'(mready_pct));
        end
        if (prev_mvalid && !prev_mready) begin
          check_eq("hold_valid", 32'(m_valid), 32'd1);
          check_eq("hold_data", m_data, prev_mdata);
        end
        if (m_valid) begin
          check_eq("push_psel", 32'(PSEL), 32'd0);
          if (!m_ready) begin
            n_stall++;
          end else begin
            n_beats++; beat_cyc.push_back(cyc);
            check_eq("beat_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check_eq("beat_data", m_data, exp_q.pop_front());
          end
        end
        if (done) begin n_done++; done_cyc = cyc; end
        if (error) begin
          n_err++;
          check_eq("err_psel", 32'(PSEL), 32'd0);
          check_eq("err_one_cycle", 32'(prev_err), 32'd0);
          err_wait = wait_run; err_prev_acc = prev_psel && prev_pen;
        end
        prev_psel = PSEL; prev_pen = PENABLE; prev_paddr = PADDR; prev_pready = PREADY;
        prev_mvalid = m_valid; prev_mready = m_ready; prev_mdata = m_data; prev_err = error;
      end
    end
  end

  task automatic run_txn(input int n, input string tag, input bit restart, output int k0);
    bit ended;
    clear_stats();
    @(negedge clk); #1;
    start = 1'b1; word_count = 16'(n); k0 = cyc;
    @(negedge clk); #1;
    start = 1'b0; ended = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (n_done + n_err > 0) begin ended = 1'b1; break; end
      start = restart && (i == 2) && busy;
      if (start) word_count = 16'($urandom_range(9, 1));
      @(negedge clk); #1;
    end
    start = 1'b0;
    check_eq({tag, "_ended"}, 32'(ended), 32'd1);
    @(negedge clk); #1;
    check_eq({tag, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  int k0;
  bit found;

  initial begin : main
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_ctl", {25'd0, busy, done, error, m_valid, PSEL, PENABLE, PWRITE}, 32'd0);
    check_eq("rst_data", m_data | PADDR | PWDATA, 32'd0);
    reset = 1'b1;

    // scenario 1: back-to-back words, no stalls
    data_src = '{32'hA1, 32'hA2, 32'hA3};
    run_txn(3, "s1", 1'b0, k0);
    check_eq("s1_beats", 32'(n_beats), 32'd3);
    check_eq("s1_first_valid", 32'(beat_cyc[0] - k0), 32'd5);
    check_eq("s1_gap1", 32'(beat_cyc[1] - beat_cyc[0]), 32'd5);
    check_eq("s1_gap2", 32'(beat_cyc[2] - beat_cyc[1]), 32'd5);
    check_eq("s1_done_cyc", 32'(done_cyc - k0), 32'd16);
    check_eq("s1_idle_cyc", 32'(cyc - k0), 32'd17);

    // scenario 2: status reports empty twice before data is available
    forced_empty = 2;
    run_txn(1, "s2", 1'b0, k0);
    check_eq("s2_stat_reads", 32'(n_stat_rd), 32'd3);
    check_eq("s2_data_reads", 32'(n_data_rd), 32'd1);
    check_eq("s2_beats", 32'(n_beats), 32'd1);

    // scenario 3: sink backpressure for 10 cycles
    mready_block = 10;
    run_txn(1, "s3", 1'b0, k0);
    check_eq("s3_stalls", 32'(n_stall), 32'd10);
    check_eq("s3_beats", 32'(n_beats), 32'd1);

    // scenario 4: slave error on the second data read
    err_at = 2;
    run_txn(4, "s4", 1'b0, k0);
    check_eq("s4_beats", 32'(n_beats), 32'd1);
    check_eq("s4_err", 32'(n_err), 32'd1);
    check_eq("s4_no_done", 32'(n_done), 32'd0);
    err_at = 0;

    // scenario 5: PREADY stuck low
    hang = 1'b1;
    run_txn(2, "s5", 1'b0, k0);
    hang = 1'b0;
    check_eq("s5_err", 32'(n_err), 32'd1);
    check_eq("s5_no_done", 32'(n_done), 32'd0);
    check_eq("s5_wait_cycles", 32'(err_wait), 32'(TO));
    check_eq("s5_psel_drop", 32'(err_prev_acc), 32'd1);
    check_eq("s5_beats", 32'(n_beats), 32'd0);

    // randomized transactions, some with a restart attempt or slave error
    for (int t = 0; t < 25; t++) begin
      int n;
      n = ($urandom_range(9, 0) == 0) ? 0 : int'($urandom_range(6, 1));
      max_wait = int'($urandom_range(4, 0));
      empty_pct = int'($urandom_range(50, 0));
      mready_pct = int'($urandom_range(100, 40));
      err_at = (n > 0 && $urandom_range(3, 0) == 0) ? int'($urandom_range(n, 1)) : 0;
      run_txn(n, "rnd", 1'b1, k0);
      if (err_at != 0) begin
        check_eq("rnd_err_beats", 32'(n_beats), 32'(err_at - 1));
        check_eq("rnd_err_pulse", 32'(n_err), 32'd1);
        check_eq("rnd_err_no_done", 32'(n_done), 32'd0);
      end else begin
        check_eq("rnd_beats", 32'(n_beats), 32'(n));
        check_eq("rnd_done", 32'(n_done), 32'd1);
        check_eq("rnd_no_err", 32'(n_err), 32'd0);
      end
      check_eq("rnd_dataq_empty", 32'(exp_q.size()), 32'd0);
      check_eq("rnd_polls", 32'(n_stat_rd - n_empty), 32'(n_data_rd));
    end
    err_at = 0; max_wait = 2; empty_pct = 0; mready_pct = 100;

    // scenario 6: reset during a data access, then an empty request
    clear_stats();
    @(negedge clk); #1;
    start = 1'b1; word_count = 16'd2;
    @(negedge clk); #1;
    start = 1'b0; found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (PSEL && PENABLE && PADDR == DA && n_beats > 0) begin found = 1'b1; break; end
      @(negedge clk); #1;
    end
    check_eq("s6_reached_data", 32'(found), 32'd1);
    reset = 1'b0;
    #1;
    check_eq("s6_rst_ctl", {25'd0, busy, done, error, m_valid, PSEL, PENABLE, PWRITE}, 32'd0);
    check_eq("s6_rst_data", m_data | PADDR | PWDATA, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    clear_stats();
    reset = 1'b1; start = 1'b1; word_count = 16'd0; k0 = cyc;
    @(negedge clk); #1;
    start = 1'b0;
    check_eq("s6_done", 32'(done), 32'd1);
    check_eq("s6_done_cyc", 32'(done_cyc - k0), 32'd1);
    @(negedge clk); #1;
    check_eq("s6_busy_low", 32'(busy), 32'd0);
    check_eq("s6_no_apb", 32'(n_psel), 32'd0);
    check_eq("s6_no_err", 32'(n_err), 32'd0);
    check_eq("s6_one_done", 32'(n_done), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
